// File: rtl/stream_burst_ctrl_pkg.sv
// Shared types for the HPU result-path egress sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//   stream_state_t : sequencer FSM states
//   SETTLE_W       : width of the settle-delay counter (SETTLE up to 15)
package stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SEND   = 2'd2
  } stream_state_t;

  localparam int SETTLE_W = 4;

endpackage

// File: rtl/stream_burst_ctrl_beat_counter.sv
// Beat index counter for one egress burst; index stops at the final beat, never wraps.
// Latency: index updates one cycle after an accepted beat.
// Backpressure: advances only on i_en (beat accepted), otherwise holds its value.
//   clk, rst     : clock, synchronous active-high reset
//   i_load_zero  : force the index back to 0 on the next edge
//   i_en         : a beat was accepted this cycle
//   i_fin        : index of the final beat of the burst
//   o_index      : current beat index
//   o_is_last    : current index equals i_fin
module beat_counter #(
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load_zero,
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_fin,
  output logic [IDX_W-1:0] o_index,
  output logic             o_is_last
);

  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
    end else if (i_load_zero) begin
      r_idx <= '0;
    end else if (i_en && !o_is_last) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  assign o_index   = r_idx;
  assign o_is_last = (r_idx == i_fin);

endmodule

// File: rtl/stream_burst_ctrl.sv
// AXI-Stream egress sequencer: each 'last' trigger waits SETTLE cycles, then emits one burst.
// Latency: trigger at cycle t -> first o_dst_valid at t+max(SETTLE,1)+1 when starting from idle.
// Backpressure: beats hold (valid/index/last stable) until i_dst_ready; extra triggers queue.
//   Optional feature macro STREAM_BURST_LEN_EN: adds i_burst_len (beats-1 per burst,
//   clamped to BEATS-1, sampled when the FSM enters SETTLE). Without it len = BEATS-1.
//   Ports: clk, rst (sync, active-high); i_last trigger; i_dst_ready = TREADY;
//   o_dst_valid = TVALID; o_dst_last = TLAST; o_stream_i beat index; o_stream_v accept
//   strobe; o_busy activity flag; o_overflow sticky lost-trigger flag.
module stream_burst_ctrl #(
  parameter int SETTLE = 2,
  parameter int BEATS  = 4,
  parameter int IDX_W  = $clog2(BEATS > 1 ? BEATS : 2),
  parameter int PEND_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_last,
  input  logic             i_dst_ready,
`ifdef STREAM_BURST_LEN_EN
  input  logic [IDX_W-1:0] i_burst_len,
`endif
  output logic             o_dst_valid,
  output logic             o_dst_last,
  output logic [IDX_W-1:0] o_stream_i,
  output logic             o_stream_v,
  output logic             o_busy,
  output logic             o_overflow
);

  import stream_pkg::*;

  localparam logic [IDX_W-1:0]    LEN_MAX     = IDX_W'(BEATS - 1);
  localparam logic [PEND_W-1:0]   PEND_MAX    = '1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE);

  stream_state_t         r_state;
  stream_state_t         w_state_nxt;
  logic [SETTLE_W-1:0]   r_settle_cnt;
  logic [PEND_W-1:0]     r_pend;
  logic                  r_ovf;
  logic [IDX_W-1:0]      w_len;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_is_last;
  logic                  w_hs;
  logic                  w_final;
  logic                  w_enter_settle;
  logic                  w_add;
  logic                  w_consume;
  logic                  w_settle_done;

  // o_dst_valid is decoded from the state register only, so i_dst_ready never
  // reaches valid/last/index combinationally.
  assign w_hs    = o_dst_valid & i_dst_ready;
  assign w_final = w_hs & w_is_last;

  // A settle count of 0 or 1 ends SETTLE this cycle; SETTLE=0 therefore still
  // spends one cycle in SETTLE.
  assign w_settle_done = (r_settle_cnt == '0) || (r_settle_cnt == SETTLE_W'(1));

  assign w_enter_settle = (r_state != stream_pkg::SETTLE) && (w_state_nxt == stream_pkg::SETTLE);

  // A trigger queues whenever it cannot start a burst directly: FSM busy, or
  // older triggers already waiting ahead of it.
  assign w_add     = i_last && ((r_state != stream_pkg::IDLE) || (r_pend != '0));
  assign w_consume = w_enter_settle && (r_pend != '0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= stream_pkg::IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      stream_pkg::IDLE: begin
        if (i_last || (r_pend != '0)) w_state_nxt = stream_pkg::SETTLE;
      end
      stream_pkg::SETTLE: begin
        if (w_settle_done) w_state_nxt = stream_pkg::SEND;
      end
      stream_pkg::SEND: begin
        if (w_final) w_state_nxt = (r_pend != '0) ? stream_pkg::SETTLE : stream_pkg::IDLE;
      end
      default: w_state_nxt = stream_pkg::IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_dst_valid = (r_state == stream_pkg::SEND);
    o_dst_last  = (r_state == stream_pkg::SEND) && w_is_last;
    o_busy      = (r_state != stream_pkg::IDLE) || (r_pend != '0);
  end

  assign o_stream_v = w_hs;
  assign o_stream_i = w_idx;
  assign o_overflow = r_ovf;

  // Settle delay: loaded on entry, counts down independently of i_dst_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle_cnt <= '0;
    end else if (w_enter_settle) begin
      r_settle_cnt <= SETTLE_LOAD;
    end else if ((r_state == stream_pkg::SETTLE) && (r_settle_cnt != '0)) begin
      r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
    end
  end

  // Pending-trigger counter. Add and consume in the same cycle cancel out, so a
  // saturated counter only loses a trigger when nothing is being consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else if (w_add && !w_consume) begin
      if (r_pend == PEND_MAX) begin
        r_ovf <= 1'b1;
      end else begin
        r_pend <= r_pend + PEND_W'(1);
      end
    end else if (w_consume && !w_add) begin
      r_pend <= r_pend - PEND_W'(1);
    end
  end

`ifdef STREAM_BURST_LEN_EN
  logic [IDX_W-1:0] r_len;

  // Length is frozen for the whole burst at SETTLE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len <= LEN_MAX;
    end else if (w_enter_settle) begin
      r_len <= (i_burst_len > LEN_MAX) ? LEN_MAX : i_burst_len;
    end
  end

  assign w_len = r_len;
`else
  assign w_len = LEN_MAX;
`endif

  // Index is held at 0 outside SEND and cleared by the final handshake, so every
  // burst (back-to-back or from idle) starts at beat 0.
  beat_counter #(
    .IDX_W (IDX_W)
  ) u_beat_counter (
    .clk         (clk),
    .rst         (rst),
    .i_load_zero ((r_state != stream_pkg::SEND) || w_final),
    .i_en        (w_hs),
    .i_fin       (w_len),
    .o_index     (w_idx),
    .o_is_last   (w_is_last)
  );

endmodule
